// File: rtl/btb_ctrl.sv
// -----------------------------------------------------------------------------
// btb_ctrl
//
// Branch-target-buffer controller for the IF/EX stages of the RISC-V core.
// Owns a direct-mapped BTB (valid, tag, target, 2-bit saturating counter per
// entry). It serves a zero-latency prediction to IF, queues resolved branches
// from EX in a 2-entry FIFO and applies them with a read-modify-write
// sequencer. After reset or a flush request it walks the table and clears
// every valid bit before accepting updates again.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   reset_n      synchronous reset, active low
//   lookup_pc    IF fetch PC
//   pred_taken   combinational: entry hit and counter predicts taken
//   pred_target  combinational: stored target when predicted taken, else pc+4
//   upd_valid    EX resolved a branch/jump this cycle
//   upd_pc       PC of the resolved instruction
//   upd_target   resolved target address
//   upd_taken    resolved direction
//   flush_req    single-cycle request to invalidate the whole table
//   ready        registered; 1 while running, 0 while clearing
//   upd_drop     registered one-cycle pulse: an update was discarded
//   fifo_count   registered update FIFO occupancy (0..2)
// -----------------------------------------------------------------------------
module btb_ctrl #(
  parameter int INDEX_BITS = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] lookup_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  input  logic        flush_req,
  output logic        ready,
  output logic        upd_drop,
  output logic [1:0]  fifo_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = 30 - INDEX_BITS;
  localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(ENTRIES - 1);

  // Main FSM
  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  // Update sequencer
  localparam logic [1:0] U_IDLE = 2'd0;
  localparam logic [1:0] U_RD   = 2'd1;
  localparam logic [1:0] U_WR   = 2'd2;

  // ---------------------------------------------------------------------------
  // Table storage
  // ---------------------------------------------------------------------------
  logic                  ent_valid_q [ENTRIES];
  logic [TAG_W-1:0]      ent_tag_q   [ENTRIES];
  logic [31:0]           ent_tgt_q   [ENTRIES];
  logic [1:0]            ent_ctr_q   [ENTRIES];

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  logic [0:0]            state_q,   state_d;
  logic [INDEX_BITS-1:0] clr_idx_q, clr_idx_d;
  logic [1:0]            ustate_q,  ustate_d;
  logic [1:0]            count_q,   count_d;
  logic                  wr_ptr_q,  wr_ptr_d;
  logic                  rd_ptr_q,  rd_ptr_d;
  logic                  drop_q,    drop_d;

  // FIFO payload; the PC is kept word-aligned, its two LSBs carry no index/tag
  logic [29:0]           fifo_pc_q  [2];
  logic [31:0]           fifo_tgt_q [2];
  logic                  fifo_tkn_q [2];

  // Update latch (head popped from the FIFO) and the entry snapshot from U_RD
  logic [29:0]           cur_pc_q;
  logic [31:0]           cur_tgt_q;
  logic                  cur_tkn_q;
  logic                  cap_hit_q;
  logic [1:0]            cap_ctr_q;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic                  running;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  flush;
  logic                  push;
  logic                  pop;
  logic                  clr_en;
  logic                  wr_en;
  logic                  tbl_we;

  logic [INDEX_BITS-1:0] lu_idx;
  logic [TAG_W-1:0]      lu_tag;
  logic                  lu_hit;

  logic [INDEX_BITS-1:0] cur_idx;
  logic [TAG_W-1:0]      cur_tag;
  logic                  rd_hit;
  logic [1:0]            new_ctr;

  logic                  unused_upd_pc_lsbs;

  assign running    = (state_q == S_RUN);
  assign fifo_full  = (count_q == 2'd2);
  assign fifo_empty = (count_q == 2'd0);
  assign flush      = running && flush_req;

  assign unused_upd_pc_lsbs = ^upd_pc[1:0];

  // ---------------------------------------------------------------------------
  // Lookup path: reads the entry registers directly, so a write on the
  // current edge is only visible from the next cycle onwards.
  // ---------------------------------------------------------------------------
  assign lu_idx      = lookup_pc[INDEX_BITS+1:2];
  assign lu_tag      = lookup_pc[31:INDEX_BITS+2];
  assign lu_hit      = ent_valid_q[lu_idx] && (ent_tag_q[lu_idx] == lu_tag);
  assign pred_taken  = running && lu_hit && ent_ctr_q[lu_idx][1];
  assign pred_target = pred_taken ? ent_tgt_q[lu_idx] : (lookup_pc + 32'd4);

  // ---------------------------------------------------------------------------
  // Update path
  // ---------------------------------------------------------------------------
  assign cur_idx = cur_pc_q[INDEX_BITS-1:0];
  assign cur_tag = cur_pc_q[29:INDEX_BITS];
  assign rd_hit  = ent_valid_q[cur_idx] && (ent_tag_q[cur_idx] == cur_tag);

  // Saturating counter step; a miss that gets written is an allocation,
  // which starts at weakly-taken.
  always_comb begin
    new_ctr = 2'b10;
    if (cap_hit_q) begin
      if (cur_tkn_q) begin
        new_ctr = (cap_ctr_q == 2'b11) ? 2'b11 : cap_ctr_q + 2'd1;
      end else begin
        new_ctr = (cap_ctr_q == 2'b00) ? 2'b00 : cap_ctr_q - 2'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    ustate_d  = ustate_q;
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    pop       = 1'b0;
    wr_en     = 1'b0;
    clr_en    = 1'b0;

    // Fullness is judged on the occupancy before this edge, so a pop on the
    // same edge does not make room for an incoming update.
    drop_d = upd_valid && (!running || fifo_full);
    push   = upd_valid && running && !fifo_full && !flush;

    if (!running) begin
      clr_en = 1'b1;
      if (clr_idx_q == LAST_IDX) begin
        state_d   = S_RUN;
        clr_idx_d = '0;
      end else begin
        clr_idx_d = clr_idx_q + INDEX_BITS'(1);
      end
    end else if (flush) begin
      // Abandon any in-flight update: the sequencer never reaches its write.
      state_d   = S_CLEAR;
      clr_idx_d = '0;
      ustate_d  = U_IDLE;
    end else begin
      unique case (ustate_q)
        U_IDLE: begin
          if (!fifo_empty) begin
            pop      = 1'b1;
            ustate_d = U_RD;
          end
        end
        U_RD: begin
          ustate_d = U_WR;
        end
        U_WR: begin
          // A not-taken miss leaves the table untouched.
          wr_en = cap_hit_q || cur_tkn_q;
          if (!fifo_empty) begin
            pop      = 1'b1;
            ustate_d = U_RD;
          end else begin
            ustate_d = U_IDLE;
          end
        end
        default: begin
          ustate_d = U_IDLE;
        end
      endcase
    end

    if (flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // A reset edge must not commit a half-finished update.
  assign tbl_we = wr_en && reset_n;

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, and reset is
  // sampled synchronously inside the clocked block.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_CLEAR;
      clr_idx_q <= '0;
      ustate_q  <= U_IDLE;
      count_q   <= 2'd0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ustate_q  <= ustate_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      drop_q    <= drop_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers: FIFO payload, update latch, entry snapshot
  // ---------------------------------------------------------------------------
  // NOTE: payload and table arrays carry no reset; their contents are only
  // observed behind control state (FIFO count, sequencer state, valid bits
  // rebuilt by the clear walk) that is reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]  <= upd_pc[31:2];
      fifo_tgt_q[wr_ptr_q] <= upd_target;
      fifo_tkn_q[wr_ptr_q] <= upd_taken;
    end
    if (pop) begin
      cur_pc_q  <= fifo_pc_q[rd_ptr_q];
      cur_tgt_q <= fifo_tgt_q[rd_ptr_q];
      cur_tkn_q <= fifo_tkn_q[rd_ptr_q];
    end
    // The snapshot is taken after any preceding write has landed, so two
    // queued updates to the same index are applied in order.
    if (running && (ustate_q == U_RD)) begin
      cap_hit_q <= rd_hit;
      cap_ctr_q <= ent_ctr_q[cur_idx];
    end
  end

  // ---------------------------------------------------------------------------
  // Table write port: the clear walk only touches valid bits.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clr_en) begin
      ent_valid_q[clr_idx_q] <= 1'b0;
    end else if (tbl_we) begin
      ent_valid_q[cur_idx] <= 1'b1;
      ent_tag_q[cur_idx]   <= cur_tag;
      ent_ctr_q[cur_idx]   <= new_ctr;
      // Not-taken hits keep the previously learned target.
      if (cur_tkn_q) begin
        ent_tgt_q[cur_idx] <= cur_tgt_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ready      = running;
  assign upd_drop   = drop_q;
  assign fifo_count = count_q;

endmodule

// File: doc/btb_ctrl.md
# btb_ctrl

Stateful branch-target-buffer controller for the pipelined RISC-V core. It owns a direct-mapped BTB with 2-bit saturating direction counters and serves a combinational prediction to the IF stage every cycle. It sequences resolved-branch updates from the EX stage through a 2-entry update FIFO and a read-modify-write FSM. It also runs the table clear sequence after reset or a flush request.

## Interface
- INDEX_BITS, 5, log2 of entry count (32 entries); index = pc[INDEX_BITS+1:2], tag = pc[31:INDEX_BITS+2]
- clk  input  1  clock; all state changes on rising edge
- reset_n  input  1  synchronous reset, active low
- lookup_pc  input  32  IF-stage fetch PC
- pred_taken  output  1  combinational: hit and counter[1]
- pred_target  output  32  combinational: stored target if pred_taken, else lookup_pc+4
- upd_valid  input  1  EX stage resolved a branch/jump this cycle
- upd_pc  input  32  PC of resolved instruction
- upd_target  input  32  resolved target address
- upd_taken  input  1  actual direction
- flush_req  input  1  single-cycle request to invalidate whole table
- ready  output  1  registered; 1 in RUN, 0 in CLEAR
- upd_drop  output  1  registered one-cycle pulse: an update was discarded
- fifo_count  output  2  registered update FIFO occupancy (0..2)

## Operation
- Entry fields: valid, tag, target[31:0], ctr[1:0] (00 SN, 01 WN, 10 WT, 11 ST).
- Lookup: hit = valid && tag match at index of lookup_pc; read from entry registers, no latency. While ready=0, pred_taken=0 and pred_target=lookup_pc+4.
- Main FSM: CLEAR, RUN.
  - CLEAR: clears valid of entry clr_idx each cycle, clr_idx 0..2^INDEX_BITS-1; after last index -> RUN; ready rises on same edge. Tag/target/ctr not cleared.
  - RUN: flush_req=1 -> CLEAR with clr_idx=0; FIFO emptied, update FSM forced to U_IDLE, in-flight update aborted (no write).
- Update FIFO, depth 2: push when upd_valid && ready && fifo_count<2. If upd_valid and (ready=0 or fifo_count==2): update discarded, upd_drop=1 next cycle. Full check uses count before this edge; push and pop on same edge keep count unchanged.
- Update FSM (RUN only): U_IDLE, U_RD, U_WR.
  - U_IDLE: FIFO non-empty -> pop head into update latch, go U_RD.
  - U_RD: capture entry (valid, tag, ctr) at head index, compute hit -> U_WR.
  - U_WR: write table, then U_RD if FIFO non-empty (pop), else U_IDLE.
- Write rules in U_WR:
  - hit, taken: ctr = min(ctr+1, 3); target = upd_target.
  - hit, not taken: ctr = max(ctr-1, 0); target unchanged.
  - miss, taken: allocate: valid=1, tag, target=upd_target, ctr=10.
  - miss, not taken: no write.
- Counter arithmetic saturates in 2 bits; never wraps.

## Timing
- Reset (reset_n=0 at edge): state=CLEAR, clr_idx=0, FIFO empty, update FSM U_IDLE, ready=0, upd_drop=0, fifo_count=0. Reset mid-clear or mid-update restarts clear at index 0.
- Clear length: exactly 2^INDEX_BITS cycles after reset release (32 for default); ready=1 in the following cycle.
- Update latency: accepted at edge E0; U_RD at E1; U_WR at E2; table written at E3; lookups after E3 see the new entry. Lookup in the same cycle as a write sees old contents.
- Throughput: one update per 2 cycles sustained; back-to-back EX updates every cycle overflow after the FIFO fills and are dropped.
- Two queued updates to the same index are applied in order; the second U_RD reads the first's result.
- flush_req while ready=0: ignored (clear already running, not restarted).

## Test plan
- Reset, release: ready=0 for 32 cycles, then 1; lookup_pc=0x100 gives pred_taken=0, pred_target=0x104.
- Update pc=0x100, target=0x200, taken: 3 edges later lookup 0x100 -> pred_taken=1, pred_target=0x200, ctr=10; two not-taken updates -> ctr=00, pred_target=0x104.
- Four taken updates to 0x100 -> ctr saturates at 11; one not-taken -> 10, still predicts taken.
- Alias: allocate 0x100, then taken update at 0x100+(32<<2)=0x180 -> entry retagged; lookup 0x100 misses, 0x180 hits.
- upd_valid high 4 consecutive cycles after idle: first three accepted (FIFO 2 plus one popped at E1), fourth dropped with upd_drop=1; fifo_count never exceeds 2.
- flush_req with FIFO holding 2 entries: ready=0 next cycle, fifo_count=0, no writes; after 32 cycles all lookups miss.
